// File: rtl/calc_op_sequencer.sv
// Calculator key-entry and operation sequencer: keypad edges to operands,
// ALU req/ack issue with result chaining, and display source selection.
module calc_op_sequencer #(
    parameter int DW         = 14,
    parameter int MAX_DIGITS = 4,
    parameter int MAXV       = 9999
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [9:0]    key_digit,
    input  logic          key_add,
    input  logic          key_sub,
    input  logic          key_eq,
    input  logic          key_clr,
    input  logic          alu_ack,
    input  logic [DW-1:0] alu_result,
    input  logic          alu_ovf,
    output logic          alu_req,
    output logic          alu_op,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [DW-1:0] disp_val,
    output logic          disp_src,
    output logic [2:0]    digit_cnt,
    output logic          busy,
    output logic          err
);

    typedef enum logic [2:0] {
        IDLE, ENTRY, ALU_REQ, ALU_WAIT, SHOW, ERROR
    } state_t;

    state_t state, n_state;

    logic [13:0] key_r, key_prev, ev;
    logic [9:0]  dig_ev;
    logic        add_ev, sub_ev, eq_ev, clr_ev, op_ev;
    logic        dig_one;
    logic [3:0]  digit;

    logic [DW-1:0] acc, operand, entry_val;
    logic          pend_valid, pend_op, chain_valid, chain_op;

    logic [DW-1:0] n_acc, n_operand, n_alu_a, n_alu_b, n_disp_val;
    logic [2:0]    n_digit_cnt;
    logic          n_pend_valid, n_pend_op, n_chain_valid, n_chain_op;
    logic          n_alu_req, n_alu_op, n_disp_src, n_busy, n_err;
    logic          start;

    assign ev     = key_r & ~key_prev;
    assign dig_ev = ev[9:0];
    assign add_ev = ev[10];
    assign sub_ev = ev[11];
    assign eq_ev  = ev[12];
    assign clr_ev = ev[13];
    assign op_ev  = add_ev ^ sub_ev;

    // Exactly one digit edge is required; simultaneous digits are dropped.
    assign dig_one = (dig_ev != '0) &&
                     ((dig_ev & (dig_ev - 10'd1)) == '0);

    always_comb begin
        digit = '0;
        for (int i = 0; i < 10; i++) begin
            if (dig_ev[i]) digit = 4'(i);
        end
    end

    assign entry_val = operand * DW'(10) + DW'(digit);

    always_comb begin
        n_state       = state;
        n_acc         = acc;
        n_operand     = operand;
        n_digit_cnt   = digit_cnt;
        n_pend_valid  = pend_valid;
        n_pend_op     = pend_op;
        n_chain_valid = chain_valid;
        n_chain_op    = chain_op;
        n_alu_req     = alu_req;
        n_alu_op      = alu_op;
        n_alu_a       = alu_a;
        n_alu_b       = alu_b;
        n_disp_val    = disp_val;
        n_disp_src    = disp_src;
        n_busy        = busy;
        n_err         = err;
        start         = 1'b0;

        if (clr_ev) begin
            n_state      = IDLE;
            n_acc        = '0;
            n_operand    = '0;
            n_digit_cnt  = '0;
            n_pend_valid = 1'b0;
            n_chain_valid = 1'b0;
            n_alu_req    = 1'b0;
            n_busy       = 1'b0;
            n_err        = 1'b0;
            n_disp_val   = '0;
            n_disp_src   = 1'b0;
        end else begin
            case (state)
                IDLE, ENTRY, SHOW: begin
                    if (eq_ev) begin
                        if (pend_valid) begin
                            start         = 1'b1;
                            n_chain_valid = 1'b0;
                        end
                    end else if (op_ev) begin
                        if (pend_valid) begin
                            start         = 1'b1;
                            n_chain_valid = 1'b1;
                            n_chain_op    = sub_ev;
                        end else begin
                            // A bare result in SHOW becomes the left operand.
                            if (!(state == SHOW && digit_cnt == '0))
                                n_acc = operand;
                            n_pend_valid = 1'b1;
                            n_pend_op    = sub_ev;
                            n_operand    = '0;
                            n_digit_cnt  = '0;
                            n_state      = SHOW;
                            n_disp_val   = n_acc;
                            n_disp_src   = 1'b1;
                        end
                    end else if (dig_one) begin
                        if (digit_cnt < 3'(MAX_DIGITS)) begin
                            n_operand = entry_val;
                            if (operand != '0 || digit != 4'd0)
                                n_digit_cnt = digit_cnt + 3'd1;
                        end
                        n_state    = ENTRY;
                        n_disp_src = 1'b0;
                        n_disp_val = n_operand;
                    end
                    if (start) begin
                        n_alu_a = acc;
                        n_alu_b = operand;
                        n_alu_op = pend_op;
                        n_state = ALU_REQ;
                    end
                end
                ALU_REQ: begin
                    n_alu_req = 1'b1;
                    n_busy    = 1'b1;
                    n_state   = ALU_WAIT;
                end
                ALU_WAIT: begin
                    if (alu_req && alu_ack) begin
                        n_alu_req = 1'b0;
                        n_busy    = 1'b0;
                        n_disp_src = 1'b1;
                        if (alu_ovf || alu_result > DW'(MAXV)) begin
                            n_state    = ERROR;
                            n_err      = 1'b1;
                            n_disp_val = '0;
                        end else begin
                            n_state      = SHOW;
                            n_acc        = alu_result;
                            n_disp_val   = alu_result;
                            n_operand    = '0;
                            n_digit_cnt  = '0;
                            n_pend_valid = chain_valid;
                            n_pend_op    = chain_op;
                        end
                    end
                end
                ERROR: ;
                default: n_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            key_r       <= '0;
            key_prev    <= '0;
            acc         <= '0;
            operand     <= '0;
            digit_cnt   <= '0;
            pend_valid  <= 1'b0;
            pend_op     <= 1'b0;
            chain_valid <= 1'b0;
            chain_op    <= 1'b0;
            alu_req     <= 1'b0;
            alu_op      <= 1'b0;
            alu_a       <= '0;
            alu_b       <= '0;
            disp_val    <= '0;
            disp_src    <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= n_state;
            key_r       <= {key_clr, key_eq, key_sub, key_add, key_digit};
            key_prev    <= key_r;
            acc         <= n_acc;
            operand     <= n_operand;
            digit_cnt   <= n_digit_cnt;
            pend_valid  <= n_pend_valid;
            pend_op     <= n_pend_op;
            chain_valid <= n_chain_valid;
            chain_op    <= n_chain_op;
            alu_req     <= n_alu_req;
            alu_op      <= n_alu_op;
            alu_a       <= n_alu_a;
            alu_b       <= n_alu_b;
            disp_val    <= n_disp_val;
            disp_src    <= n_disp_src;
            busy        <= n_busy;
            err         <= n_err;
        end
    end

endmodule

// File: doc/calc_op_sequencer.md
Name: calc_op_sequencer

Overview:
- Key-entry and operation sequencer for the natural-number calculator datapath.
- Turns level keypad inputs (digits 0-9, add, sub, equals, clear) into decimal operands, issues operations to the shared ALU over a req/ack handshake, chains results, and selects what the seg/LCD display path shows.
- Sits between the keypad switch inputs and the ALU/display blocks.

Parameters:
- DW, 14, operand/result width in bits.
- MAX_DIGITS, 4, maximum decimal digits per operand.
- MAXV, 9999, largest legal operand/result value.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- key_digit  in  10  digit keys; bit n = digit n; level, held many cycles per press
- key_add  in  1  add key, level
- key_sub  in  1  subtract key, level
- key_eq  in  1  equals key, level
- key_clr  in  1  clear key, level
- alu_ack  in  1  ALU result valid; sampled only while alu_req=1
- alu_result  in  DW  ALU result
- alu_ovf  in  1  ALU overflow or borrow, qualified by alu_ack
- alu_req  out  1  operation request
- alu_op  out  1  0=add, 1=sub
- alu_a  out  DW  accumulator operand
- alu_b  out  DW  entry operand
- disp_val  out  DW  value to display
- disp_src  out  1  0=entry operand, 1=result
- digit_cnt  out  3  digits entered in current operand
- busy  out  1  ALU operation outstanding
- err  out  1  error latched

Behaviour:
- Reset (rst=0 at a clk edge): all outputs 0; acc, operand and pending-op cleared; state IDLE; key history registers cleared. Reset overrides any state, including an outstanding alu_req.
- Edge detect: each key input is registered once. An event is key & ~key_prev, so one press produces exactly one event regardless of hold time. The event is acted on in the cycle after the rising edge is sampled.
- Same-cycle events resolve by priority: clr > eq > add/sub > digit.
  - add and sub together: both ignored.
  - More than one digit edge: all digits ignored.
- States: IDLE, ENTRY, ALU_REQ, ALU_WAIT, SHOW, ERROR.
- Digit event in IDLE, ENTRY or SHOW:
  - If digit_cnt < MAX_DIGITS: operand <= operand*10 + d.
  - digit_cnt increments unless operand=0 and d=0; leading zeros do not count.
  - At MAX_DIGITS, further digits are ignored.
  - Go to ENTRY; disp_src=0; disp_val=operand.
- add/sub event in IDLE, ENTRY or SHOW:
  - No pending op: acc <= operand (in SHOW with digit_cnt=0, acc keeps the result). Set pending op to add/sub, clear operand and digit_cnt, go to SHOW with disp_val=acc and disp_src=1.
  - Pending op present: go to ALU_REQ with alu_a=acc, alu_b=operand, alu_op=pending, and record the new key as the next pending op.
- eq event: with a pending op, go to ALU_REQ and clear pending after completion. With no pending op, no action.
- ALU_REQ: assert alu_req=1 and busy=1 on the next cycle; go to ALU_WAIT. alu_a, alu_b and alu_op stay stable while alu_req=1.
- ALU_WAIT: alu_req stays high until alu_ack=1 is sampled. ack may arrive in the first cycle req is high.
  - On ack with alu_ovf=0 and alu_result<=MAXV: acc <= alu_result; alu_req and busy drop on the next cycle; disp_val=acc; disp_src=1; operand and digit_cnt cleared; go to SHOW.
  - On ack with alu_ovf=1 or alu_result>MAXV: go to ERROR.
- While busy, digit/add/sub/eq events are discarded (not queued). clr aborts immediately: alu_req drops next cycle, and a late alu_ack is ignored.
- ERROR: err=1, disp_val=0, disp_src=1. Only clr exits.
- clr event in any state: acc, operand, pending and err cleared; go to IDLE; disp_val=0; disp_src=0.
- Latency: digit edge to disp_val update is 2 cycles. Op edge to alu_req is 2 cycles. alu_ack to disp_val update is 1 cycle.

Test Plan:
- Digits 2,3; add; digits 4,5,6; add -> alu_a=23, alu_b=456, alu_op=0; ALU acks 479 -> disp_val=479, disp_src=1. Then digits 2,3,4 -> disp_val=234, disp_src=0, digit_cnt=3.
- Digits 1,2,3,4,5 (each held 1000 cycles) -> disp_val=1234 and digit_cnt=4; the fifth digit and hold time cause no repeats. Digits 0,0,7 -> operand=7, digit_cnt=1.
- Operands 50 sub 80 eq, ALU acks with alu_ovf=1 -> err=1, disp_val=0. A later digit 5 is ignored; clr -> err=0, IDLE, disp_val=0.
- ALU delays ack 20 cycles -> alu_req stays high with stable alu_a/alu_b, busy=1. An add pressed meanwhile is discarded, so exactly one operation completes.
- clr during ALU_WAIT, then a late ack -> alu_req=0 next cycle, acc stays 0, no SHOW. Separately, rst=0 mid-entry -> all outputs 0 next cycle.
- key_add and key_sub rise in the same cycle -> no action. key_clr and a digit rise together -> clear wins and operand=0.
